// File: rtl/mem_arb_pkg.sv
// Shared defaults, FSM encoding and ticket sizing
// for the N-channel memory arbiter.
package mem_arb_pkg;

  localparam int N_CH_DEF      = 3;
  localparam int AW_DEF        = 64;
  localparam int DW_DEF        = 64;
  localparam int REQ_DEPTH_DEF = 4;
  localparam int MAX_OUTST_DEF = 32;
  localparam int WR_RESP_DEF   = 1;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } issue_state_t;

  function automatic int tkt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_nch_fifo.sv
// Small synchronous FIFO with registered flags
// and first-word-fall-through output.
module arb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic [PW:0]   cnt_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_comb begin
    cnt_nxt = cnt + (PW+1)'(do_push)
                  - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == FULL_C);
    end
  end

endmodule

// File: rtl/mem_arbiter_nch.sv
// Round-robin arbiter of N client channels onto
// one in-order memory port, with response routing.
module mem_arbiter_nch
  import mem_arb_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int REQ_DEPTH = REQ_DEPTH_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF,
  parameter int WR_RESP   = WR_RESP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  we,
  input  logic [N_CH*AW-1:0] addr,
  input  logic [N_CH*DW-1:0] wdata,
  output logic [N_CH-1:0]  gnt,
  output logic [N_CH-1:0]  valid,
  output logic [N_CH*DW-1:0] rdata,
  output logic             mem_req,
  input  logic             mem_ready,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_valid,
  input  logic [DW-1:0]    mem_rdata,
  output logic             resp_err
);

  localparam int TW = tkt_w(N_CH);
  localparam int EW = 1 + AW + DW;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam logic [OW:0] MAX_C = (OW+1)'(MAX_OUTST);
  localparam bit  WR_TKT = (WR_RESP != 0);

  logic [EW-1:0]   ch_dout [N_CH];
  logic [N_CH-1:0] ch_empty;
  logic [N_CH-1:0] ch_full;
  logic [N_CH-1:0] ch_push;
  logic [N_CH-1:0] ch_pop;

  issue_state_t state, state_nxt;
  logic [TW-1:0] rr_ptr, rr_nxt;
  logic [TW-1:0] winner;
  logic [TW-1:0] mem_id;
  logic [EW-1:0] win_ent;
  logic          found;
  logic          win;
  logic          slot_ok;
  logic          infl;
  logic [OW:0]   occ;

  logic [TW-1:0] tkt_id;
  logic          tkt_empty;
  logic          tkt_full;
  logic          tkt_push;
  logic          tkt_pop;
  logic          hs;
  logic [OW-1:0] outst_cnt;

  assign gnt     = ~ch_full;
  assign ch_push = req & ~ch_full;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    arb_fifo #(
      .W    (EW),
      .DEPTH(REQ_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (ch_push[gi]),
      .din  ({we[gi],
              addr[gi*AW +: AW],
              wdata[gi*DW +: DW]}),
      .pop  (ch_pop[gi]),
      .dout (ch_dout[gi]),
      .empty(ch_empty[gi]),
      .full (ch_full[gi])
    );
  end

  // Rotating priority: first pass from rr_ptr up, then wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && !ch_empty[i] &&
          TW'(i) >= rr_ptr) begin
        found  = 1'b1;
        winner = TW'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!found && !ch_empty[i]) begin
        found  = 1'b1;
        winner = TW'(i);
      end
    end
  end

  assign rr_nxt = (winner == TW'(N_CH-1))
                ? '0 : winner + 1'b1;

  assign hs      = mem_req && mem_ready;
  assign infl    = mem_req && (!mem_we || WR_TKT);
  assign tkt_pop = mem_valid && !tkt_empty;
  assign tkt_push = hs && (!mem_we || WR_TKT)
                 && !tkt_full;

  // The held request already owns a ticket slot.
  assign occ     = {1'b0, outst_cnt} + (OW+1)'(infl);
  assign slot_ok = (occ < MAX_C) || tkt_pop;

  assign win = found && slot_ok &&
               (state == S_IDLE || mem_ready);

  always_comb begin
    ch_pop  = '0;
    win_ent = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_pop[i] = win && (winner == TW'(i));
      if (winner == TW'(i)) win_ent = ch_dout[i];
    end
  end

  always_comb begin
    state_nxt = state;
    if (win)
      state_nxt = S_ISSUE;
    else if (state == S_ISSUE && mem_ready)
      state_nxt = S_IDLE;
  end

  assign mem_req = (state == S_ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_id    <= '0;
    end else begin
      state <= state_nxt;
      if (win) begin
        rr_ptr    <= rr_nxt;
        mem_we    <= win_ent[EW-1];
        mem_addr  <= win_ent[AW+DW-1:DW];
        mem_wdata <= win_ent[DW-1:0];
        mem_id    <= winner;
      end
    end
  end

  arb_fifo #(
    .W    (TW),
    .DEPTH(MAX_OUTST)
  ) u_tkt (
    .clk  (clk),
    .rst  (rst),
    .push (tkt_push),
    .din  (mem_id),
    .pop  (tkt_pop),
    .dout (tkt_id),
    .empty(tkt_empty),
    .full (tkt_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_cnt <= '0;
      resp_err  <= 1'b0;
    end else begin
      unique case ({tkt_push, tkt_pop})
        2'b10:   outst_cnt <= outst_cnt + 1'b1;
        2'b01:   outst_cnt <= outst_cnt - 1'b1;
        default: outst_cnt <= outst_cnt;
      endcase
      if (mem_valid && tkt_empty) resp_err <= 1'b1;
    end
  end

  always_comb begin
    valid = '0;
    rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      valid[i] = tkt_pop && (tkt_id == TW'(i));
      if (valid[i]) rdata[i*DW +: DW] = mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Directed bench for mem_arbiter_nch: latency,
// round-robin, stalls, ticket limits, errors.
module tb_mem_arbiter_nch;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req, we, gnt, valid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata, rdata;
  logic            mem_req, mem_ready, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            mem_valid, resp_err;

  logic [N-1:0]    b_req, b_we, b_gnt, b_valid;
  logic [N*AW-1:0] b_addr;
  logic [N*DW-1:0] b_wdata, b_rdata;
  logic            b_mem_req, b_mem_ready, b_mem_we;
  logic [AW-1:0]   b_mem_addr;
  logic [DW-1:0]   b_mem_wdata, b_mem_rdata;
  logic            b_mem_valid, b_resp_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter_nch #(
    .N_CH(N), .AW(AW), .DW(DW), .REQ_DEPTH(4),
    .MAX_OUTST(4), .WR_RESP(1)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt),
    .valid(valid), .rdata(rdata),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .resp_err(resp_err)
  );

  mem_arbiter_nch #(
    .N_CH(N), .AW(AW), .DW(DW), .REQ_DEPTH(4),
    .MAX_OUTST(4), .WR_RESP(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .req(b_req), .we(b_we),
    .addr(b_addr), .wdata(b_wdata), .gnt(b_gnt),
    .valid(b_valid), .rdata(b_rdata),
    .mem_req(b_mem_req), .mem_ready(b_mem_ready),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_valid(b_mem_valid),
    .mem_rdata(b_mem_rdata), .resp_err(b_resp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; we = '0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_valid = 1'b0;
    mem_rdata = '0;
    b_req = '0; b_we = '0; b_addr = '0;
    b_wdata = '0; b_mem_ready = 1'b0;
    b_mem_valid = 1'b0; b_mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] exp_rr(int j);
    return 16'(((j % 3) << 8) | (j / 3));
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    #1;
    checks++; if (gnt !== 3'b111) begin errors++;
      $display("FAIL rst_gnt got=%b exp=111", gnt); end
    checks++; if (valid !== 3'b000) begin errors++;
      $display("FAIL rst_valid got=%b exp=000", valid); end
    checks++; if (rdata !== '0) begin errors++;
      $display("FAIL rst_rdata got=%h exp=0", rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++;
      $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++;
      $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++;
      $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin errors++;
      $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (resp_err !== 1'b0) begin errors++;
      $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 3'b010;
    addr = {16'h0000, 16'h0040, 16'h0000};
    #1;
    checks++; if (gnt[1] !== 1'b1) begin errors++;
      $display("FAIL single_gnt got=%b exp=1", gnt[1]); end
    tick();
    req = '0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++;
      $display("FAIL single_t1 mem_req got=%b exp=0", mem_req); end
    tick();
    mem_ready = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++;
      $display("FAIL single_t2 mem_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 16'h0040) begin errors++;
      $display("FAIL single_addr got=%h exp=0040", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++;
      $display("FAIL single_we got=%b exp=0", mem_we); end
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (valid !== 3'b000) begin errors++;
        $display("FAIL single_wait valid got=%b exp=000", valid); end
      tick();
    end
    mem_valid = 1'b1;
    mem_rdata = 16'hDEAD;
    #1;
    checks++; if (valid !== 3'b010) begin errors++;
      $display("FAIL single_valid got=%b exp=010", valid); end
    checks++; if (rdata !== {16'h0, 16'hDEAD, 16'h0}) begin
      errors++;
      $display("FAIL single_rdata got=%h exp=0000dead0000", rdata); end
    tick();
    mem_valid = 1'b0;
    #1;
    checks++; if (resp_err !== 1'b0) begin errors++;
      $display("FAIL single_err got=%b exp=0", resp_err); end
  endtask

  task automatic test_round_robin();
    int iss = 0, rsp = 0, first = -1, last = -1;
    logic [15:0] ed;
    do_reset();
    mem_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && rsp < 12; cyc++) begin
      if (cyc < 4) begin
        req = 3'b111;
        addr = {16'h0200 | 16'(cyc), 16'h0100 | 16'(cyc),
                16'(cyc)};
      end else req = '0;
      mem_valid = (rsp < iss);
      ed = exp_rr(rsp) ^ 16'hC000;
      mem_rdata = mem_valid ? ed : 16'h0;
      #1;
      if (cyc < 4) begin
        checks++; if (gnt !== 3'b111) begin errors++;
          $display("FAIL rr_gnt got=%b exp=111", gnt); end
      end
      if (mem_valid) begin
        checks++;
        if (valid !== (3'b001 << (rsp % 3)) ||
            rdata[(rsp % 3)*16 +: 16] !== ed) begin
          errors++;
          $display("FAIL rr_resp%0d valid=%b data=%h exp_ch=%0d exp_data=%h",
                   rsp, valid, rdata, rsp % 3, ed);
        end
        rsp++;
      end
      if (mem_req && mem_ready) begin
        checks++; if (mem_addr !== exp_rr(iss)) begin errors++;
          $display("FAIL rr_issue%0d got=%h exp=%h",
                   iss, mem_addr, exp_rr(iss)); end
        if (first < 0) first = cyc;
        last = cyc;
        iss++;
      end
      tick();
    end
    mem_valid = 1'b0;
    checks++; if (iss != 12 || rsp != 12) begin errors++;
      $display("FAIL rr_count iss=%0d rsp=%0d exp=12", iss, rsp); end
    checks++; if (last - first != 11) begin errors++;
      $display("FAIL rr_throughput span=%0d exp=11", last - first); end
  endtask

  task automatic test_stall();
    int iss = 0, rsp = 0, acc = 0;
    logic [15:0] ea;
    do_reset();
    for (int cyc = 0; cyc < 60 && rsp < 6; cyc++) begin
      req[0] = (cyc == 0);
      req[1] = (cyc >= 2 && acc < 5);
      req[2] = 1'b0;
      addr = {16'h0, 16'h0B00 | 16'(acc), 16'h0AAA};
      mem_ready = (cyc >= 7);
      mem_valid = (rsp < iss);
      ea = (rsp == 0) ? 16'h0AAA : 16'h0B00 | 16'(rsp - 1);
      mem_rdata = ea ^ 16'hC000;
      #1;
      if (cyc >= 2 && cyc <= 6) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0AAA) begin
          errors++;
          $display("FAIL stall_hold c%0d req=%b addr=%h exp=1/0aaa",
                   cyc, mem_req, mem_addr);
        end
      end
      if (cyc == 6 || cyc == 7) begin
        checks++; if (gnt[1] !== 1'b0 || acc != 4) begin errors++;
          $display("FAIL stall_full c%0d gnt1=%b acc=%0d exp=0/4",
                   cyc, gnt[1], acc); end
      end
      if (req[1] && gnt[1]) acc++;
      if (mem_valid) begin
        checks++;
        if (valid !== ((rsp == 0) ? 3'b001 : 3'b010) ||
            rdata !== ((rsp == 0) ? {32'h0, mem_rdata}
                                  : {16'h0, mem_rdata, 16'h0})) begin
          errors++;
          $display("FAIL stall_resp%0d valid=%b data=%h",
                   rsp, valid, rdata);
        end
        rsp++;
      end
      if (mem_req && mem_ready) begin
        ea = (iss == 0) ? 16'h0AAA : 16'h0B00 | 16'(iss - 1);
        checks++; if (mem_addr !== ea) begin errors++;
          $display("FAIL stall_issue%0d got=%h exp=%h",
                   iss, mem_addr, ea); end
        iss++;
      end
      tick();
    end
    req = '0;
    mem_valid = 1'b0;
    checks++; if (acc != 5 || iss != 6 || rsp != 6) begin
      errors++;
      $display("FAIL stall_count acc=%0d iss=%0d rsp=%0d exp=5/6/6",
               acc, iss, rsp); end
  endtask

  task automatic test_outstanding();
    int iss = 0;
    logic [15:0] eo [6];
    eo = '{16'h0A00, 16'h0B00, 16'h0A01,
           16'h0B01, 16'h0A02, 16'h0A03};
    do_reset();
    mem_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      req = {1'b0, cyc < 2, cyc < 4};
      addr = {16'h0, 16'h0B00 | 16'(cyc),
              16'h0A00 | 16'(cyc)};
      mem_valid = (cyc == 12);
      mem_rdata = 16'h1111;
      #1;
      if (cyc == 12) begin
        checks++; if (iss != 4 || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL outst_block iss=%0d mem_req=%b exp=4/0",
                   iss, mem_req); end
        checks++;
        if (valid !== 3'b001 || rdata !== 48'h1111) begin
          errors++;
          $display("FAIL outst_resp valid=%b data=%h exp=001/1111",
                   valid, rdata); end
      end
      if (cyc == 13) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0A02) begin
          errors++;
          $display("FAIL outst_fifth req=%b addr=%h exp=1/0a02",
                   mem_req, mem_addr); end
      end
      if (mem_req && mem_ready) begin
        if (iss < 6) begin
          checks++; if (mem_addr !== eo[iss]) begin errors++;
            $display("FAIL outst_issue%0d got=%h exp=%h",
                     iss, mem_addr, eo[iss]); end
        end
        iss++;
      end
      tick();
    end
    mem_valid = 1'b0;
    checks++; if (iss != 5) begin errors++;
      $display("FAIL outst_total got=%0d exp=5", iss); end
  endtask

  task automatic test_wr_noresp();
    do_reset();
    b_mem_ready = 1'b1;
    b_req   = 3'b101;
    b_we    = 3'b001;
    b_addr  = {16'h0020, 16'h0, 16'h0010};
    b_wdata = {16'h0, 16'h0, 16'h1234};
    #1;
    checks++; if (b_gnt !== 3'b111) begin errors++;
      $display("FAIL wr_gnt got=%b exp=111", b_gnt); end
    tick();
    b_req = '0;
    tick();
    #1;
    checks++;
    if (b_mem_req !== 1'b1 || b_mem_we !== 1'b1 ||
        b_mem_addr !== 16'h0010 ||
        b_mem_wdata !== 16'h1234) begin
      errors++;
      $display("FAIL wr_issue req=%b we=%b addr=%h wd=%h exp=1/1/0010/1234",
               b_mem_req, b_mem_we, b_mem_addr, b_mem_wdata);
    end
    tick();
    #1;
    checks++;
    if (b_mem_req !== 1'b1 || b_mem_we !== 1'b0 ||
        b_mem_addr !== 16'h0020) begin
      errors++;
      $display("FAIL wr_read_issue req=%b we=%b addr=%h exp=1/0/0020",
               b_mem_req, b_mem_we, b_mem_addr);
    end
    tick();
    tick();
    b_mem_valid = 1'b1;
    b_mem_rdata = 16'hBEEF;
    #1;
    checks++;
    if (b_valid !== 3'b100 ||
        b_rdata !== {16'hBEEF, 32'h0}) begin
      errors++;
      $display("FAIL wr_route valid=%b data=%h exp=100/beef00000000",
               b_valid, b_rdata);
    end
    tick();
    b_mem_rdata = 16'h7777;
    #1;
    checks++; if (b_valid !== 3'b000) begin errors++;
      $display("FAIL wr_extra valid=%b exp=000", b_valid); end
    tick();
    b_mem_valid = 1'b0;
    #1;
    checks++; if (b_resp_err !== 1'b1) begin errors++;
      $display("FAIL wr_err got=%b exp=1", b_resp_err); end
  endtask

  task automatic test_err_reset();
    do_reset();
    mem_valid = 1'b1;
    mem_rdata = 16'h5555;
    #1;
    checks++; if (valid !== 3'b000 || rdata !== '0) begin
      errors++;
      $display("FAIL err_valid valid=%b data=%h exp=000/0",
               valid, rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++;
      $display("FAIL err_early got=%b exp=0", resp_err); end
    tick();
    mem_valid = 1'b0;
    #1;
    checks++; if (resp_err !== 1'b1) begin errors++;
      $display("FAIL err_sticky got=%b exp=1", resp_err); end
    req  = 3'b111;
    addr = {16'h0303, 16'h0202, 16'h0101};
    tick();
    req = '0;
    tick();
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0101) begin
      errors++;
      $display("FAIL rstm_pre req=%b addr=%h exp=1/0101",
               mem_req, mem_addr); end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== '0 ||
        mem_we !== 1'b0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL rstm_mem req=%b addr=%h we=%b wd=%h exp=0",
               mem_req, mem_addr, mem_we, mem_wdata); end
    checks++;
    if (gnt !== 3'b111 || valid !== 3'b000 ||
        resp_err !== 1'b0) begin
      errors++;
      $display("FAIL rstm_out gnt=%b valid=%b err=%b exp=111/000/0",
               gnt, valid, resp_err); end
    tick();
    rst = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++;
      $display("FAIL rstm_flush mem_req=%b exp=0", mem_req); end
    mem_valid = 1'b1;
    #1;
    checks++; if (valid !== 3'b000) begin errors++;
      $display("FAIL rstm_late valid=%b exp=000", valid); end
    tick();
    mem_valid = 1'b0;
    #1;
    checks++; if (resp_err !== 1'b1) begin errors++;
      $display("FAIL rstm_late_err got=%b exp=1", resp_err); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_outstanding();
    test_wr_noresp();
    test_err_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_nch.md
MEM_ARBITER_NCH -- requirements
Module: mem_arbiter_nch

Interface
REQ-001 Parameter N_CH, default 3, number of client channels (1..8).
REQ-002 Parameter AW, default 64, address width.
REQ-003 Parameter DW, default 64, data width.
REQ-004 Parameter REQ_DEPTH, default 4, per-channel request FIFO depth (power of 2, >=2).
REQ-005 Parameter MAX_OUTST, default 32, maximum outstanding responses (power of 2).
REQ-006 Parameter WR_RESP, default 1; 1 = memory returns mem_valid for writes, 0 = reads only.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 req  in  N_CH  per-channel request strobe.
REQ-010 we  in  N_CH  per-channel write enable.
REQ-011 addr  in  N_CH*AW  flattened addresses, channel i at [i*AW +: AW].
REQ-012 wdata  in  N_CH*DW  flattened write data, same packing.
REQ-013 gnt  out  N_CH  channel FIFO has space (combinational, = !full).
REQ-014 valid  out  N_CH  per-channel response strobe.
REQ-015 rdata  out  N_CH*DW  flattened response data.
REQ-016 mem_req  out  1  memory request valid (registered).
REQ-017 mem_ready  in  1  memory accepts request this cycle.
REQ-018 mem_we / mem_addr / mem_wdata  out  1/AW/DW  registered request payload.
REQ-019 mem_valid / mem_rdata  in  1/DW  in-order memory response.
REQ-020 resp_err  out  1  sticky: response arrived with no ticket pending.

Function
REQ-021 Channel i request accepted when req[i] && gnt[i]; with gnt[i] low, request is not accepted and the client holds it.
REQ-022 Issue FSM: IDLE (mem_req=0) -> ISSUE on arbitration win; ISSUE holds mem_req and payload stable until mem_req && mem_ready, then -> ISSUE (back-to-back) if another winner is eligible that cycle, else -> IDLE.
REQ-023 Arbitration: round-robin; search starts at rr_ptr, first non-empty channel wins; rr_ptr <= (winner+1) mod N_CH.
REQ-024 Arbitration is blocked while outstanding count == MAX_OUTST; the winner's FIFO pops in the winning cycle only.
REQ-025 Idle latency: request accepted in cycle t -> mem_req high in cycle t+2.
REQ-026 Sustained throughput: one memory request per cycle while mem_ready=1 and any FIFO non-empty.
REQ-027 Ticket (channel id, clog2(N_CH) bits, min 1) pushed at handshake if we=0 or WR_RESP=1; writes with WR_RESP=0 push no ticket.
REQ-028 Response routing combinational, same cycle: mem_valid with ticket present -> valid[id]=1, rdata slice id=mem_rdata, ticket popped; all other slices 0.
REQ-029 mem_valid with no ticket pending: discarded, resp_err set to 1 until reset.
REQ-030 Outstanding counter: +1 on ticket push, -1 on pop, unchanged on simultaneous push and pop; never exceeds MAX_OUTST.
REQ-031 Full FIFO with simultaneous pop: gnt stays low that cycle (no same-cycle refill).
REQ-032 N_CH=1: rr_ptr constant 0, behaviour otherwise identical.

Reset
REQ-033 On rst: all FIFOs and ticket queue empty, rr_ptr=0, FSM=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_err=0, counter=0.
REQ-034 Reset mid-transaction discards queued and in-flight state; memory is reset together; late responses set resp_err.

Structure
REQ-035 Shared package mem_arb_pkg holds default parameter values and the ticket-width function.
REQ-036 One sub-module arb_fifo (parametrised width/depth, async reset, registered empty/full, first-word output) instantiated N_CH times plus once for tickets.

Verification
REQ-037 Single read ch1, addr 0x40, memory latency 3 -> mem_req at t+2, valid[1]=1 with mem_rdata=0xDEAD, other valids 0.
REQ-038 All 3 channels push 4 reads each, mem_ready=1 -> issue order 0,1,2,0,1,2...; responses routed in same order.
REQ-039 mem_ready=0 for 5 cycles mid-burst -> mem_req/payload stable; channel gnt drops after 4 accepts; no loss.
REQ-040 MAX_OUTST=4, memory withholds responses -> exactly 4 issued, 5th issued cycle after first mem_valid.
REQ-041 WR_RESP=0, ch0 write then ch2 read -> one ticket; single mem_valid goes to valid[2].
REQ-042 mem_valid with nothing outstanding -> resp_err=1, no valid; rst mid-burst -> all outputs at reset values.
